vliw_issue_scoreboard: RTL and testbench

Register scoreboard and issue interlock for the six-slot VLIW core (ADD, MUL, FPA, FPM, LU, MEM). Tracks each register's outstanding write-back with a per-register countdown and holds back a decoded bundle while any slot reads or overwrites a register whose result is still in flight. Sits between the decode stage and the functional-unit operand latches. Only accepted bundles may launch into the execute units.

---
 rtl/vliw_issue_scoreboard_pkg.sv | 40 ++++
 rtl/vliw_issue_scoreboard_if.sv | 38 +++
 rtl/vliw_issue_scoreboard_sb_reg_counter.sv | 66 ++++++
 rtl/vliw_issue_scoreboard.sv | 140 ++++++++++++++
 tb/tb_vliw_issue_scoreboard.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_issue_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// vliw_sb_pkg
// Shared constants for the VLIW issue scoreboard. It holds the register file
// geometry, the slot numbering of the six-slot bundle, the default
// write-back latencies per slot, and a small latency-merge helper.
// There are no ports: this is a package.
// -----------------------------------------------------------------------------
package vliw_sb_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int NSLOT = 6;
  localparam int CW    = 4;

  // Destination index NSLOT is the MUL low-half destination (dst2).
  localparam int NDST  = NSLOT + 1;

  localparam int SLOT_ADD = 0;
  localparam int SLOT_MUL = 1;
  localparam int SLOT_FPA = 2;
  localparam int SLOT_FPM = 3;
  localparam int SLOT_LU  = 4;
  localparam int SLOT_MEM = 5;

  localparam int LAT_ADD_DEF = 4;
  localparam int LAT_MUL_DEF = 13;
  localparam int LAT_FPA_DEF = 4;
  localparam int LAT_FPM_DEF = 4;
  localparam int LAT_LU_DEF  = 1;
  localparam int LAT_MEM_DEF = 2;

  typedef logic [REG_W-1:0] regNum_t;
  typedef logic [CW-1:0]    cnt_t;

  // When several destinations hit one register, the longest write-back wins.
  function automatic cnt_t maxLat(input cnt_t a, input cnt_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vliw_issue_scoreboard_if.sv
// -----------------------------------------------------------------------------
// vliw_issue_scoreboard_if
// Connects the decode stage to the issue scoreboard.
//   bundle_valid / bundle_ready : issue handshake (issue = valid & ready)
//   src_a, src_b, *_en           : per-slot source registers
//   dst, dst_en, dst2, dst2_en   : per-slot destinations plus the MUL low half
//   busy_vec, illegal_bundle,
//   stall_cycles                 : scoreboard status back to the core
// The master modport is the decode side. The slave modport is the scoreboard.
// -----------------------------------------------------------------------------
interface vliw_issue_scoreboard_if;
  import vliw_sb_pkg::*;

  logic                          bundle_valid;
  logic                          bundle_ready;
  logic [NSLOT-1:0][REG_W-1:0]   src_a;
  logic [NSLOT-1:0][REG_W-1:0]   src_b;
  logic [NSLOT-1:0]              src_a_en;
  logic [NSLOT-1:0]              src_b_en;
  logic [NSLOT-1:0][REG_W-1:0]   dst;
  logic [NSLOT-1:0]              dst_en;
  logic [REG_W-1:0]              dst2;
  logic                          dst2_en;
  logic [NREG-1:0]               busy_vec;
  logic                          illegal_bundle;
  logic [15:0]                   stall_cycles;

  modport master (
    output bundle_valid, src_a, src_b, src_a_en, src_b_en, dst, dst_en, dst2, dst2_en,
    input  bundle_ready, busy_vec, illegal_bundle, stall_cycles
  );

  modport slave (
    input  bundle_valid, src_a, src_b, src_a_en, src_b_en, dst, dst_en, dst2, dst2_en,
    output bundle_ready, busy_vec, illegal_bundle, stall_cycles
  );

endinterface

// File: rtl/vliw_issue_scoreboard_sb_reg_counter.sv
// -----------------------------------------------------------------------------
// sb_reg_counter
// Write-back countdown for one tracked register.
//   clk, rst  : clock, synchronous active-high reset
//   load, lat : load the counter with lat (load has priority over decrement)
//   count     : current countdown value
//   busy      : count != 0
//   srcHold   : a reader of this register must still wait
// Configuration macro VLIW_SB_BYPASS_EN: when it is defined, srcHold drops at
// count == 1 because the write-back is forwarded. When it is not defined,
// srcHold drops only at count == 0.
// -----------------------------------------------------------------------------
module sb_reg_counter
  import vliw_sb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  cnt_t  lat,
  output cnt_t  count,
  output logic  busy,
  output logic  srcHold
);

  localparam cnt_t CNT_ZERO = {CW{1'b0}};
  localparam cnt_t CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  cnt_t cnt_r;
  cnt_t cntNext_s;
  logic busy_r;
  logic hold_r;

  // Next countdown value: load wins over decrement, and the counter stops at zero.
  always_comb begin
    cntNext_s = cnt_r;
    if (load) begin
      cntNext_s = lat;
    end else if (cnt_r != CNT_ZERO) begin
      cntNext_s = cnt_r - CNT_ONE;
    end else begin
      cntNext_s = cnt_r;
    end
  end

  // Counter and its status flags are registered together, so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= CNT_ZERO;
      busy_r <= 1'b0;
      hold_r <= 1'b0;
    end else begin
      cnt_r  <= cntNext_s;
      busy_r <= (cntNext_s != CNT_ZERO);
`ifdef VLIW_SB_BYPASS_EN
      hold_r <= (cntNext_s > CNT_ONE);
`else
      hold_r <= (cntNext_s != CNT_ZERO);
`endif
    end
  end

  assign count   = cnt_r;
  assign busy    = busy_r;
  assign srcHold = hold_r;

endmodule

// File: rtl/vliw_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// vliw_issue_scoreboard
// Register scoreboard and issue interlock for the six-slot VLIW core.
//   clk, rst : clock, synchronous active-high reset
//   sb       : slave side of vliw_issue_scoreboard_if (bundle in, ready and
//              status out)
// A bundle is held back (bundle_ready = 0) by a RAW hazard on any enabled
// source, or by a WAW hazard on any enabled destination. A WAW hazard exists
// when the pending count of the destination is >= the latency of the new write.
// R0 is never tracked.
// Configuration macro VLIW_SB_BYPASS_EN: when it is defined, sources whose
// write-back lands on the issue edge count as ready. This is handled inside
// sb_reg_counter.
// -----------------------------------------------------------------------------
module vliw_issue_scoreboard
  import vliw_sb_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_FPA = LAT_FPA_DEF,
  parameter int LAT_FPM = LAT_FPM_DEF,
  parameter int LAT_LU  = LAT_LU_DEF,
  parameter int LAT_MEM = LAT_MEM_DEF
)
(
  input  logic                    clk,
  input  logic                    rst,
  vliw_issue_scoreboard_if.slave  sb
);

  localparam regNum_t R0       = {REG_W{1'b0}};
  localparam cnt_t    CNT_ZERO = {CW{1'b0}};

  // Latency of destination index d. Index NSLOT is the MUL low half.
  function automatic cnt_t dstLat(input int d);
    case (d)
      SLOT_ADD: return CW'(LAT_ADD);
      SLOT_MUL: return CW'(LAT_MUL);
      SLOT_FPA: return CW'(LAT_FPA);
      SLOT_FPM: return CW'(LAT_FPM);
      SLOT_LU:  return CW'(LAT_LU);
      SLOT_MEM: return CW'(LAT_MEM);
      NSLOT:    return CW'(LAT_MUL);
      default:  return CNT_ZERO;
    endcase
  endfunction

  cnt_t     [NREG-1:0]  cnt_s;
  logic     [NREG-1:0]  busy_s;
  logic     [NREG-1:0]  hold_s;
  regNum_t  [NDST-1:0]  dReg_s;
  logic     [NDST-1:0]  dLive_s;
  logic                 hazard_s;
  logic                 collide_s;
  logic                 issue_s;
  logic                 illegal_r;
  logic     [15:0]      stall_r;

  assign dReg_s = {sb.dst2, sb.dst};

  // A destination counts only if it is enabled and is not R0.
  always_comb begin
    dLive_s = {NDST{1'b0}};
    for (int d = 0; d < NDST; d++) begin
      dLive_s[d] = (d == NSLOT) ? (sb.dst2_en && dReg_s[d] != R0)
                                : (sb.dst_en[d] && dReg_s[d] != R0);
    end
  end

  // RAW and WAW interlock. It does not depend on bundle_valid.
  always_comb begin
    hazard_s = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      hazard_s = hazard_s | (sb.src_a_en[s] && sb.src_a[s] != R0 && hold_s[sb.src_a[s]]);
      hazard_s = hazard_s | (sb.src_b_en[s] && sb.src_b[s] != R0 && hold_s[sb.src_b[s]]);
    end
    for (int d = 0; d < NDST; d++) begin
      hazard_s = hazard_s | (dLive_s[d] && cnt_s[dReg_s[d]] >= dstLat(d));
    end
  end

  // Detects when two live destinations of the bundle target the same register.
  always_comb begin
    collide_s = 1'b0;
    for (int i = 0; i < NDST; i++) begin
      for (int j = i + 1; j < NDST; j++) begin
        collide_s = collide_s | (dLive_s[i] && dLive_s[j] && dReg_s[i] == dReg_s[j]);
      end
    end
  end

  assign issue_s = sb.bundle_valid && !hazard_s;

  assign cnt_s[0]  = CNT_ZERO;
  assign busy_s[0] = 1'b0;
  assign hold_s[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gReg
    cnt_t lat_s;

    // Latency loaded into this register: the maximum over all live destinations that hit it.
    always_comb begin
      lat_s = CNT_ZERO;
      for (int d = 0; d < NDST; d++) begin
        lat_s = (dLive_s[d] && dReg_s[d] == REG_W'(r)) ? maxLat(lat_s, dstLat(d)) : lat_s;
      end
    end

    sb_reg_counter uCnt (
      .clk     (clk),
      .rst     (rst),
      .load    (issue_s && lat_s != CNT_ZERO),
      .lat     (lat_s),
      .count   (cnt_s[r]),
      .busy    (busy_s[r]),
      .srcHold (hold_s[r])
    );
  end

  // Illegal-bundle pulse (one cycle after issue) and saturating stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
      stall_r   <= 16'h0000;
    end else begin
      illegal_r <= issue_s && collide_s;
      if (sb.bundle_valid && hazard_s && stall_r != 16'hFFFF) begin
        stall_r <= stall_r + 16'h0001;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign sb.bundle_ready   = !hazard_s;
  assign sb.busy_vec       = busy_s;
  assign sb.illegal_bundle = illegal_r;
  assign sb.stall_cycles   = stall_r;

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_vliw_issue_scoreboard
// Self-checking bench for vliw_issue_scoreboard. The reference model records,
// for each register, the absolute edge at which its write-back lands. The
// pending count is that edge minus the edges elapsed so far.
// Each cycle, the driver pushes the expected outputs into a queue. A monitor
// pops that queue and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_vliw_issue_scoreboard;
  import vliw_sb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vliw_issue_scoreboard_if sbIf ();

  vliw_issue_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbIf)
  );

`ifdef VLIW_SB_BYPASS_EN
  localparam int RAW_SLACK = 1;
`else
  localparam int RAW_SLACK = 0;
`endif

  // ADD, MUL, FPA, FPM, LU, MEM, then the MUL low half.
  int latTab [7] = '{4, 13, 4, 4, 1, 2, 13};

  typedef struct packed {
    logic            valid;
    logic [5:0][4:0] srcA;
    logic [5:0][4:0] srcB;
    logic [5:0][4:0] dst;
    logic [5:0]      aEn;
    logic [5:0]      bEn;
    logic [5:0]      dEn;
    logic [4:0]      dst2;
    logic            d2En;
  } bundle_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] busy;
    logic        illegal;
    logic [15:0] stall;
  } exp_t;

  exp_t expQ [$];
  int   wb [32];
  int   nEdge   = 0;
  int   stallM  = 0;
  logic illegalM = 1'b0;
  int   nChecks = 0;
  int   nPass   = 0;

  function automatic int remaining(input int r);
    return (wb[r] > nEdge) ? (wb[r] - nEdge) : 0;
  endfunction

  function automatic bundle_t emptyB();
    bundle_t b;
    b = '0;
    return b;
  endfunction

  // Destination k of a bundle. Index 6 is dst2.
  function automatic int dstReg(input bundle_t b, input int k);
    if (k < 6) return (b.dEn[k] ? int'(b.dst[k]) : 0);
    return (b.d2En ? int'(b.dst2) : 0);
  endfunction

  function automatic logic modelReady(input bundle_t b);
    logic ok;
    ok = 1'b1;
    for (int s = 0; s < 6; s++) begin
      if (b.aEn[s] && b.srcA[s] != 5'd0 && remaining(int'(b.srcA[s])) > RAW_SLACK) ok = 1'b0;
      if (b.bEn[s] && b.srcB[s] != 5'd0 && remaining(int'(b.srcB[s])) > RAW_SLACK) ok = 1'b0;
    end
    for (int k = 0; k < 7; k++) begin
      if (dstReg(b, k) != 0 && remaining(dstReg(b, k)) >= latTab[k]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // Drive one cycle, queue its expectation, then advance the model past the next edge.
  task automatic step(input bundle_t b, input logic doRst, input logic check, output logic issued);
    exp_t e;
    logic rdy;
    int   hits [32];
    int   best [32];
    @(negedge clk);
    rst               = doRst;
    sbIf.bundle_valid = b.valid;
    sbIf.src_a        = b.srcA;
    sbIf.src_b        = b.srcB;
    sbIf.src_a_en     = b.aEn;
    sbIf.src_b_en     = b.bEn;
    sbIf.dst          = b.dst;
    sbIf.dst_en       = b.dEn;
    sbIf.dst2         = b.dst2;
    sbIf.dst2_en      = b.d2En;
    rdy       = modelReady(b);
    e.ready   = rdy;
    for (int r = 0; r < 32; r++) e.busy[r] = (remaining(r) != 0);
    e.illegal = illegalM;
    e.stall   = 16'(stallM);
    if (check) expQ.push_back(e);
    issued = b.valid && rdy && !doRst;
    if (doRst) begin
      for (int r = 0; r < 32; r++) wb[r] = 0;
      stallM   = 0;
      illegalM = 1'b0;
    end else begin
      if (b.valid && !rdy && stallM < 65535) stallM++;
      illegalM = 1'b0;
      if (issued) begin
        for (int r = 0; r < 32; r++) begin
          hits[r] = 0;
          best[r] = 0;
        end
        for (int k = 0; k < 7; k++) begin
          if (dstReg(b, k) != 0) begin
            hits[dstReg(b, k)]++;
            if (latTab[k] > best[dstReg(b, k)]) best[dstReg(b, k)] = latTab[k];
          end
        end
        for (int r = 1; r < 32; r++) begin
          if (hits[r] > 1) illegalM = 1'b1;
          if (best[r] > 0) wb[r] = nEdge + 1 + best[r];
        end
      end
    end
    nEdge++;
  endtask

  task automatic idle(input int n);
    logic iss;
    for (int i = 0; i < n; i++) step(emptyB(), 1'b0, 1'b1, iss);
  endtask

  // Present a bundle until the model accepts it. The bound is there in case the model never accepts.
  task automatic untilIssue(input bundle_t b, input string name);
    logic iss;
    iss = 1'b0;
    for (int k = 0; k < 40 && !iss; k++) step(b, 1'b0, 1'b1, iss);
    if (!iss) begin
      nChecks++;
      $display("FAIL %s issue timeout actual=stalled required=issued", name);
    end
  endtask

  // Monitor: compares the DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("bundle_ready",   {31'd0, sbIf.bundle_ready},   {31'd0, e.ready});
        chk("busy_vec",       sbIf.busy_vec,                e.busy);
        chk("illegal_bundle", {31'd0, sbIf.illegal_bundle}, {31'd0, e.illegal});
        chk("stall_cycles",   {16'd0, sbIf.stall_cycles},   {16'd0, e.stall});
      end
    end
  end

  initial begin
    bundle_t b;
    logic    iss;
    rst = 1'b1;
    b = emptyB();
    sbIf.bundle_valid = 1'b0;
    sbIf.src_a = '0; sbIf.src_b = '0; sbIf.src_a_en = '0; sbIf.src_b_en = '0;
    sbIf.dst = '0;   sbIf.dst_en = '0; sbIf.dst2 = '0;   sbIf.dst2_en = 1'b0;
    for (int r = 0; r < 32; r++) wb[r] = 0;
    step(b, 1'b1, 1'b0, iss);
    step(b, 1'b1, 1'b0, iss);

    // After reset: an arbitrary bundle that is not valid must see ready.
    b = emptyB();
    for (int s = 0; s < 6; s++) begin
      b.srcA[s] = 5'($urandom_range(31)); b.srcB[s] = 5'($urandom_range(31));
      b.dst[s]  = 5'($urandom_range(31));
    end
    b.aEn = 6'h3F; b.bEn = 6'h3F; b.dEn = 6'h3F;
    step(b, 1'b0, 1'b1, iss);

    // RAW: ADD R3 <- R1 + R2, then an LU that reads R3.
    b = emptyB(); b.valid = 1'b1;
    b.dEn[0] = 1'b1; b.dst[0] = 5'd3;
    b.aEn[0] = 1'b1; b.srcA[0] = 5'd1; b.bEn[0] = 1'b1; b.srcB[0] = 5'd2;
    step(b, 1'b0, 1'b1, iss);
    b = emptyB(); b.valid = 1'b1; b.aEn[4] = 1'b1; b.srcA[4] = 5'd3;
    untilIssue(b, "raw_add");
    idle(6);

    // MUL R5:R6, then a reader of R6.
    b = emptyB(); b.valid = 1'b1;
    b.dEn[1] = 1'b1; b.dst[1] = 5'd5; b.d2En = 1'b1; b.dst2 = 5'd6;
    step(b, 1'b0, 1'b1, iss);
    b = emptyB(); b.valid = 1'b1; b.aEn[0] = 1'b1; b.srcA[0] = 5'd6;
    untilIssue(b, "mul_reader");
    idle(3);

    // R0 everywhere, issued back to back.
    b = emptyB(); b.valid = 1'b1;
    b.aEn = 6'h3F; b.bEn = 6'h3F; b.dEn = 6'h3F; b.d2En = 1'b1;
    for (int i = 0; i < 4; i++) step(b, 1'b0, 1'b1, iss);

    // WAW: MUL R7, then LU R7.
    b = emptyB(); b.valid = 1'b1; b.dEn[1] = 1'b1; b.dst[1] = 5'd7;
    step(b, 1'b0, 1'b1, iss);
    b = emptyB(); b.valid = 1'b1; b.dEn[4] = 1'b1; b.dst[4] = 5'd7;
    untilIssue(b, "waw_lu");
    // A shorter write followed by a longer write issues at once.
    b = emptyB(); b.valid = 1'b1; b.dEn[0] = 1'b1; b.dst[0] = 5'd8;
    step(b, 1'b0, 1'b1, iss);
    b = emptyB(); b.valid = 1'b1; b.dEn[1] = 1'b1; b.dst[1] = 5'd8;
    step(b, 1'b0, 1'b1, iss);
    idle(15);

    // Illegal bundle: ADD and FPA both write R9. Reset two cycles later.
    b = emptyB(); b.valid = 1'b1;
    b.dEn[0] = 1'b1; b.dst[0] = 5'd9; b.dEn[2] = 1'b1; b.dst[2] = 5'd9;
    step(b, 1'b0, 1'b1, iss);
    idle(1);
    step(emptyB(), 1'b1, 1'b1, iss);
    idle(3);

    // Random traffic over a small register window, so that hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      b = emptyB();
      b.valid = ($urandom_range(3) != 0);
      for (int s = 0; s < 6; s++) begin
        if ($urandom_range(3) == 0) begin b.aEn[s] = 1'b1; b.srcA[s] = 5'($urandom_range(11)); end
        if ($urandom_range(5) == 0) begin b.bEn[s] = 1'b1; b.srcB[s] = 5'($urandom_range(11)); end
        if ($urandom_range(4) == 0) begin b.dEn[s] = 1'b1; b.dst[s]  = 5'($urandom_range(11)); end
      end
      if ($urandom_range(5) == 0) begin b.d2En = 1'b1; b.dst2 = 5'($urandom_range(11)); end
      step(b, ($urandom_range(149) == 0), 1'b1, iss);
    end
    idle(2);

    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
    #5;
    if (expQ.size() > 0) begin
      nChecks++;
      $display("FAIL drain actual=%0d required=0 pending expectations", expQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
